// File: rtl/matmul_pkg.sv
// Shared constants, load-FSM states and element-to-lane mapping for the 2x2 matmul datapath.
package matmul_pkg;

   localparam int ELEM_W    = 8;
   localparam int FRAME_LEN = 8;
   localparam int OP_W      = 4 * ELEM_W;

   typedef enum logic [1:0] {
      S_FILL_A    = 2'd0,
      S_FILL_B    = 2'd1,
      S_ERR_FLUSH = 2'd2
   } load_state_e;

   // Element k of a frame lands in byte lane lane_of(k); lane 3 is the MSB (x00).
   function automatic logic [1:0] lane_of(input logic [2:0] k, input logic col_major_b);
      logic [1:0] lane;
      lane = 2'd3 - k[1:0];
      if (k[2] && col_major_b) begin
         case (k[1:0])
            2'd0:    lane = 2'd3;
            2'd1:    lane = 2'd1;
            2'd2:    lane = 2'd2;
            default: lane = 2'd0;
         endcase
      end
      return lane;
   endfunction

endpackage

// File: rtl/matmul_operand_loader_if.sv
// Element stream in, packed operand pair out, plus occupancy and sticky error status.
interface matmul_operand_loader_if;
   import matmul_pkg::*;

   logic [ELEM_W-1:0] in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   logic              op_valid;
   logic              op_ready;
   logic [1:0]        occupancy;
   logic              err;
   logic              err_clr;

   modport master (
      output in_data, in_valid, in_last, op_ready, err_clr,
      input  in_ready, op_a, op_b, op_valid, occupancy, err
   );

   modport slave (
      input  in_data, in_valid, in_last, op_ready, err_clr,
      output in_ready, op_a, op_b, op_valid, occupancy, err
   );

endinterface

// File: rtl/matload_pingpong_buf.sv
// Two-slot ping-pong operand store: frames are assembled in slot[wr_ptr] and presented from slot[rd_ptr].
module matload_pingpong_buf
   import matmul_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              wr_sel_b,
   input  logic [1:0]        wr_lane,
   input  logic [ELEM_W-1:0] wr_data,
   input  logic              commit,
   input  logic              op_ready,
   output logic [OP_W-1:0]   op_a,
   output logic [OP_W-1:0]   op_b,
   output logic              op_valid,
   output logic [1:0]        occupancy
);

   logic [1:0][3:0][ELEM_W-1:0] slot_a_q, slot_a_d;
   logic [1:0][3:0][ELEM_W-1:0] slot_b_q, slot_b_d;
   logic                        wr_ptr_q, wr_ptr_d;
   logic                        rd_ptr_q, rd_ptr_d;
   logic [1:0]                  occ_q, occ_d;
   logic                        op_valid_q, op_valid_d;
   logic                        pop;

   assign pop = op_valid_q && op_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         slot_a_q   <= '0;
         slot_b_q   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         occ_q      <= 2'd0;
         op_valid_q <= 1'b0;
      end else begin
         slot_a_q   <= slot_a_d;
         slot_b_q   <= slot_b_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         op_valid_q <= op_valid_d;
      end
   end

   // The write slot is never the presented slot while a pair is pending, so writes cannot disturb op_a/op_b.
   always_comb begin
      slot_a_d = slot_a_q;
      slot_b_d = slot_b_q;
      if (wr_en) begin
         if (wr_sel_b) slot_b_d[wr_ptr_q][wr_lane] = wr_data;
         else          slot_a_d[wr_ptr_q][wr_lane] = wr_data;
      end
      wr_ptr_d = wr_ptr_q ^ commit;
      rd_ptr_d = rd_ptr_q ^ pop;
      occ_d    = occ_q;
      case ({commit, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
      op_valid_d = (occ_d != 2'd0);
   end

   assign op_a      = slot_a_q[rd_ptr_q];
   assign op_b      = slot_b_q[rd_ptr_q];
   assign op_valid  = op_valid_q;
   assign occupancy = occ_q;

endmodule

// File: rtl/matmul_operand_loader.sv
// Frames an element stream into A/B operand pairs and resynchronises on framing errors.
// Define MATLOAD_COLMAJOR_B_EN to accept B elements in column-major order.
module matmul_operand_loader
   import matmul_pkg::*;
(
   input logic                   clk,
   input logic                   rst,
   matmul_operand_loader_if.slave bus
);

`ifdef MATLOAD_COLMAJOR_B_EN
   localparam logic COL_MAJOR_B = 1'b1;
`else
   localparam logic COL_MAJOR_B = 1'b0;
`endif

   load_state_e state_q, state_d;
   logic [2:0]  elem_cnt_q, elem_cnt_d;
   logic        err_q, err_d;
   logic        in_ready, beat, last_beat;
   logic        commit, frame_err, wr_en;
   logic [1:0]  occupancy;

   // Flushing never stalls, so a lost frame boundary is always recoverable.
   assign in_ready  = rst && ((state_q == S_ERR_FLUSH) || (occupancy != 2'd2));
   assign beat      = bus.in_valid && in_ready;
   assign last_beat = (elem_cnt_q == 3'(FRAME_LEN - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_FILL_A;
         elem_cnt_q <= 3'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         elem_cnt_q <= elem_cnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      elem_cnt_d = elem_cnt_q;
      if (beat) begin
         case (state_q)
            S_FILL_A: begin
               if (bus.in_last) begin
                  elem_cnt_d = 3'd0;
               end else begin
                  elem_cnt_d = elem_cnt_q + 3'd1;
                  if (elem_cnt_q == 3'd3) state_d = S_FILL_B;
               end
            end
            S_FILL_B: begin
               if (last_beat) begin
                  elem_cnt_d = 3'd0;
                  state_d    = bus.in_last ? S_FILL_A : S_ERR_FLUSH;
               end else if (bus.in_last) begin
                  elem_cnt_d = 3'd0;
                  state_d    = S_FILL_A;
               end else begin
                  elem_cnt_d = elem_cnt_q + 3'd1;
               end
            end
            S_ERR_FLUSH: begin
               if (bus.in_last) begin
                  elem_cnt_d = 3'd0;
                  state_d    = S_FILL_A;
               end
            end
            default: begin
               elem_cnt_d = 3'd0;
               state_d    = S_FILL_A;
            end
         endcase
      end
   end

   always_comb begin
      wr_en     = 1'b0;
      commit    = 1'b0;
      frame_err = 1'b0;
      if (beat && (state_q != S_ERR_FLUSH)) begin
         wr_en = 1'b1;
         if (last_beat) begin
            commit    = bus.in_last;
            frame_err = !bus.in_last;
         end else begin
            frame_err = bus.in_last;
         end
      end
      // A new error wins over a coincident clear.
      err_d = frame_err ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
   end

   matload_pingpong_buf u_buf (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_sel_b  (elem_cnt_q[2]),
      .wr_lane   (lane_of(elem_cnt_q, COL_MAJOR_B)),
      .wr_data   (bus.in_data),
      .commit    (commit),
      .op_ready  (bus.op_ready),
      .op_a      (bus.op_a),
      .op_b      (bus.op_b),
      .op_valid  (bus.op_valid),
      .occupancy (occupancy)
   );

   assign bus.in_ready  = in_ready;
   assign bus.occupancy = occupancy;
   assign bus.err       = err_q;

endmodule
